// File: rtl/ot_soc_top.sv
// ot_soc_top - minimal SoC top level.
//
// After reset, sends the 32-bit identity code LSB byte first over an 8N1 UART
// (optional). After that, every correctly framed byte received on the UART
// is sent back out on the same UART through a 4-entry FIFO. A single GPIO
// input is synchronised and driven onto the GPIO output.
//
// Ports:
//   clk_i    sole clock, rising edge
//   rst_ni   asynchronous active-low reset
//   uart_rx  UART receive line (asynchronous, idles high)
//   uart_tx  UART transmit line (registered, idles high)
//   gpio_i   general-purpose input (asynchronous)
//   gpio_o   general-purpose output (gpio_i after a 2-flop synchroniser)
module ot_soc_top #(
    parameter logic [31:0] JTAG_ID      = 32'h0000_0001,
    parameter logic        DirectDmiTap = 1'b1,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic uart_rx,
    output logic uart_tx,
    input  logic gpio_i,
    output logic gpio_o
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BANNER_N  = DirectDmiTap ? 3'd4 : 3'd0;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    // ------------------------------------------------------------------
    // Synchronisers. Reset low so a line held low through reset can never
    // look like an idle-high line and arm the receiver.
    // ------------------------------------------------------------------
    logic [1:0] rx_sync_q, rx_sync_d;
    logic [1:0] gpio_sync_q, gpio_sync_d;
    logic       rx_s;

    assign rx_sync_d   = {rx_sync_q[0], uart_rx};
    assign gpio_sync_d = {gpio_sync_q[0], gpio_i};
    assign rx_s        = rx_sync_q[1];

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_armed_q, rx_armed_d;
    logic          rx_push;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_armed_d = rx_armed_q | rx_s;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_armed_q && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half a bit after the edge: still low means a real start bit.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    // A low stop bit discards the byte and disarms until the
                    // line is seen high, so a stuck-low line yields nothing.
                    if (rx_s) rx_push    = 1'b1;
                    else      rx_armed_d = 1'b0;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Echo FIFO (4 entries). A pop in the same cycle frees a slot for a push.
    // ------------------------------------------------------------------
    logic [3:0][7:0] fifo_q, fifo_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]      fifo_cnt_q, fifo_cnt_d;
    logic            fifo_pop, push_ok;

    assign push_ok = rx_push && ((fifo_cnt_q != 3'd4) || fifo_pop);

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = rx_shift_q;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (fifo_pop) rd_ptr_d = rd_ptr_q + 2'd1;
        fifo_cnt_d = fifo_cnt_q + {2'b00, push_ok} - {2'b00, fifo_pop};
    end

    // ------------------------------------------------------------------
    // Transmitter and banner sequencing
    // ------------------------------------------------------------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic [2:0]    banner_left_q, banner_left_d;
    logic          banner_pend, tx_ready, tx_load;
    logic [1:0]    banner_idx;
    logic [7:0]    load_byte;

    assign banner_pend = (banner_left_q != 3'd0);
    assign banner_idx  = 2'(3'd4 - banner_left_q);
    // Loading in the last stop-bit cycle makes consecutive frames back-to-back.
    assign tx_ready    = (tx_state_q == TX_IDLE) ||
                         (tx_state_q == TX_STOP && tx_cnt_q == BIT_LAST);
    assign tx_load     = tx_ready && (banner_pend || fifo_cnt_q != 3'd0);
    assign fifo_pop    = tx_ready && !banner_pend && (fifo_cnt_q != 3'd0);

    always_comb begin
        unique case (banner_idx)
            2'd0:    load_byte = JTAG_ID[7:0];
            2'd1:    load_byte = JTAG_ID[15:8];
            2'd2:    load_byte = JTAG_ID[23:16];
            default: load_byte = JTAG_ID[31:24];
        endcase
        if (!banner_pend) load_byte = fifo_q[rd_ptr_q];
    end

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        tx_d          = tx_q;
        banner_left_d = banner_left_q;
        unique case (tx_state_q)
            TX_IDLE: ;
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = load_byte;
            tx_d       = 1'b0;
            if (banner_pend) banner_left_d = banner_left_q - 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_q     <= '0;
            gpio_sync_q   <= '0;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_armed_q    <= 1'b0;
            fifo_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_q          <= 1'b1;
            banner_left_q <= BANNER_N;
        end else begin
            rx_sync_q     <= rx_sync_d;
            gpio_sync_q   <= gpio_sync_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_armed_q    <= rx_armed_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_q          <= tx_d;
            banner_left_q <= banner_left_d;
        end
    end

    assign uart_tx = tx_q;
    assign gpio_o  = gpio_sync_q[1];

endmodule

// File: tb/tb_ot_soc_top.sv
// Bench for ot_soc_top: reference model schedules UART frames (banner bytes,
// then echoes of received bytes through a 4-deep queue) and the expected
// uart_tx level is derived arithmetically from the frame list each cycle.
module tb_ot_soc_top;
    localparam int          CPB = 16;
    localparam logic [31:0] JID = 32'h0000_0001;

    logic clk = 1'b0, rst_ni = 1'b0, uart_rx = 1'b0, gpio_i = 1'b0;
    logic uart_tx, gpio_o, tx_nb, gpio_o_nb;
    logic rx_nb = 1'b1;

    always #5 clk = ~clk;

    ot_soc_top #(.JTAG_ID(JID), .DirectDmiTap(1'b1), .CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .gpio_i(gpio_i), .gpio_o(gpio_o));

    ot_soc_top #(.JTAG_ID(JID), .DirectDmiTap(1'b0), .CLKS_PER_BIT(CPB)) dut_nb (
        .clk_i(clk), .rst_ni(rst_ni), .uart_rx(rx_nb), .uart_tx(tx_nb),
        .gpio_i(gpio_i), .gpio_o(gpio_o_nb));

    // ---------------- model state ----------------
    int         cyc = 0;
    bit         started = 0;
    int         tx_free, banner_left;
    logic [7:0] fifo_m[$];
    int         fr_s[$];
    logic [7:0] fr_b[$];
    bit         fr_ban[$];
    int         pq_c[$];
    logic [7:0] pq_d[$];
    logic       g1 = 1'b0, g2 = 1'b0;
    int         n_chk = 0, n_fail = 0;
    bit         gpio_run = 0;
    int         R, T, T2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic exp_line(input int c);
        logic [7:0] b;
        int idx;
        for (int i = 0; i < fr_s.size(); i++) begin
            if (c >= fr_s[i] && c < fr_s[i] + 10*CPB) begin
                idx = (c - fr_s[i]) / CPB;
                b = fr_b[i];
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return b[idx-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic bit in_echo(input int c);
        for (int i = 0; i < fr_s.size(); i++)
            if (!fr_ban[i] && c >= fr_s[i] - 1 && c <= fr_s[i] + 10*CPB) return 1;
        return 0;
    endfunction

    // Model: one step per rising edge. A free transmitter starts a frame
    // (banner bytes first, then queued echoes); then any byte whose stop bit
    // is sampled this edge joins the queue if there is room.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_ni) begin
            started = 0;
            fifo_m.delete(); fr_s.delete(); fr_b.delete(); fr_ban.delete();
            pq_c.delete(); pq_d.delete();
            g1 = 1'b0; g2 = 1'b0;
        end else begin
            g2 = g1; g1 = gpio_i;
            if (!started) begin
                started = 1; tx_free = cyc; banner_left = 4;
            end
            if (cyc >= tx_free) begin
                if (banner_left > 0) begin
                    fr_s.push_back(cyc); fr_b.push_back(JID[8*(4-banner_left) +: 8]);
                    fr_ban.push_back(1); banner_left--; tx_free = cyc + 10*CPB;
                end else if (fifo_m.size() > 0) begin
                    fr_s.push_back(cyc); fr_b.push_back(fifo_m.pop_front());
                    fr_ban.push_back(0); tx_free = cyc + 10*CPB;
                end
            end
            while (pq_c.size() > 0 && pq_c[0] <= cyc) begin
                if (pq_c[0] == cyc && fifo_m.size() < 4) fifo_m.push_back(pq_d[0]);
                void'(pq_c.pop_front()); void'(pq_d.pop_front());
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!rst_ni) begin
            chk("tx_in_reset", uart_tx, 1);
            chk("gpio_in_reset", gpio_o, 0);
            chk("tx_nb_in_reset", tx_nb, 1);
        end else begin
            logic e;
            e = exp_line(cyc);
            n_chk++;
            if (uart_tx !== e && !(in_echo(cyc) &&
                (uart_tx === exp_line(cyc-1) || uart_tx === exp_line(cyc+1)))) begin
                n_fail++;
                $display("FAIL uart_tx at cycle %0d: got %0b, expected %0b", cyc, uart_tx, e);
            end
            chk("gpio_o", gpio_o, g2);
            chk("tx_no_banner", tx_nb, 1);
            chk("gpio_o_nb", gpio_o_nb, g2);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(input int t);
        do @(negedge clk); while (cyc < t);
        if (cyc != t) begin
            n_chk++; n_fail++;
            $display("FAIL at_cyc: reached cycle %0d, required %0d", cyc, t);
        end
    endtask

    // Stop bit sampled 9.5 bits after the synchronised start edge, which the
    // receiver sees 3 edges after the line falls (2 sync flops + idle sample).
    task automatic send_frame(input logic [7:0] b, input int stop_len, input bit ferr);
        int e0;
        @(posedge clk); #1;
        e0 = cyc;
        uart_rx = 1'b0;
        if (!ferr) begin
            pq_c.push_back(e0 + 3 + CPB/2 + 9*CPB); pq_d.push_back(b);
        end
        wait_edges(CPB);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            wait_edges(CPB);
        end
        if (ferr) begin
            uart_rx = 1'b0; wait_edges(CPB + 40);
            uart_rx = 1'b1; wait_edges(8);
        end else begin
            uart_rx = 1'b1; wait_edges(stop_len);
        end
    endtask

    task automatic glitch();
        @(posedge clk); #1;
        uart_rx = 1'b0; wait_edges(3);
        uart_rx = 1'b1; wait_edges(12);
    endtask

    task automatic dec_lit(input int s, input logic [7:0] expb, input string nm);
        logic [7:0] got;
        at_cyc(s);
        chk({nm, "_start"}, uart_tx, 0);
        for (int k = 0; k < 8; k++) begin
            at_cyc(s + CPB*(k+1) + CPB/2);
            got[k] = uart_tx;
        end
        chk(nm, got, expb);
        at_cyc(s + 9*CPB + CPB/2);
        chk({nm, "_stop"}, uart_tx, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] ovf[6];
        int k;
        logic [7:0] b;
        ovf[0] = 8'h5A; ovf[1] = 8'h3C; ovf[2] = 8'h81;
        ovf[3] = 8'hFF; ovf[4] = 8'h00; ovf[5] = 8'h96;

        // Reset held with rx low, then banner with rx stuck low.
        repeat (4) @(negedge clk);
        chk("reset_tx", uart_tx, 1);
        rst_ni = 1'b1;
        R = cyc + 1;
        at_cyc(R);       chk("banner_first_start", uart_tx, 0);
        at_cyc(R + 16);  chk("banner_b0_bit0", uart_tx, 1);
        at_cyc(R + 32);  chk("banner_b0_bit1", uart_tx, 0);
        at_cyc(R + 152); chk("banner_b0_stop", uart_tx, 1);
        at_cyc(R + 160); chk("banner_b1_start", uart_tx, 0);
        at_cyc(R + 640); chk("banner_done_idle", uart_tx, 1);
        at_cyc(R + 800); chk("stuck_low_no_echo", uart_tx, 1);
        chk("stuck_low_fifo_empty", fifo_m.size(), 0);
        gpio_i = 1'b1;
        at_cyc(R + 801); chk("gpio_one_edge", gpio_o, 0);
        at_cyc(R + 802); chk("gpio_two_edges", gpio_o, 1);

        // Echo after the banner: two bytes in order.
        uart_rx = 1'b1;
        wait_edges(10);
        T = cyc;
        fork
            begin send_frame(8'h5A, 16, 0); send_frame(8'hC3, 16, 0); end
            begin dec_lit(T + 1 + 156, 8'h5A, "echo_5a"); dec_lit(T + 1 + 317, 8'hC3, "echo_c3"); end
        join

        // Reset asserted in the middle of an echoed byte.
        wait_edges(5);
        T2 = cyc;
        fork send_frame(8'h00, 16, 0); join_none
        at_cyc(T2 + 1 + 156 + 40); chk("pre_reset_tx_low", uart_tx, 0);
        #3 rst_ni = 1'b0;
        #1 chk("async_reset_tx", uart_tx, 1);
        chk("async_reset_gpio", gpio_o, 0);
        repeat (4) @(negedge clk);
        rst_ni = 1'b1;
        R = cyc + 1;

        // Six bytes arriving from the start of the banner; the first waits
        // for the banner and goes out right after it.
        gpio_run = 1;
        fork
            while (gpio_run) begin
                wait_edges(1 + $urandom_range(0, 29));
                gpio_i = ~gpio_i;
            end
        join_none
        fork
            begin
                wait_edges(2);
                for (int i = 0; i < 6; i++) send_frame(ovf[i], 14, 0);
            end
            dec_lit(R + 640, 8'h5A, "echo_after_banner");
        join
        wait_edges(1200);

        // Random traffic: good frames, framing errors, start glitches.
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 9);
            b = 8'($urandom);
            wait_edges($urandom_range(0, 99));
            if (k < 7)      send_frame(b, 14 + $urandom_range(0, 19), 0);
            else if (k < 9) send_frame(b, 0, 1);
            else            glitch();
        end
        wait_edges(1500);
        gpio_run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule
